// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the fetch-side and execute-side handshakes of the decode stage.
//   Fetch side  : in_valid, in_ready, instr, pc_in, flush
//   Execute side: out_valid, out_ready, instructions, rs1/rs2/rd_addr, imm, PC, illegal,
//                 dec_count
// Modports: slave  = decoder view (drives outputs, samples inputs)
//           master = surrounding pipeline view
interface decode_stage_if #(
    parameter int unsigned OPW = 47
);
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    instr;
    logic [31:0]    pc_in;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] instructions;
    logic [4:0]     rs1_addr;
    logic [4:0]     rs2_addr;
    logic [4:0]     rd_addr;
    logic [31:0]    imm;
    logic [31:0]    PC;
    logic           illegal;
    logic [31:0]    dec_count;

    modport slave (
        input  in_valid, instr, pc_in, flush, out_ready,
        output in_ready, out_valid, instructions, rs1_addr, rs2_addr, rd_addr, imm, PC,
               illegal, dec_count
    );

    modport master (
        output in_valid, instr, pc_in, flush, out_ready,
        input  in_ready, out_valid, instructions, rs1_addr, rs2_addr, rd_addr, imm, PC,
               illegal, dec_count
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I(+M) instruction decoder with a single registered output stage.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - decode_stage_if.slave: fetch handshake (in_valid/in_ready/instr/pc_in/flush) and
//          execute handshake (out_valid/out_ready) plus the decoded bundle
//          (instructions one-hot, register indices, imm, PC, illegal) and dec_count.
// Optional feature: define DECODE_RV32M_EN to decode the RV32M ops (one-hot bits 37-44);
// otherwise those words decode as illegal.
module decode_stage #(
    parameter int unsigned OPW = 47
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [46:0] op;
    fmt_e        fmt;
    logic [31:0] imm_dec;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    // Combinational decode of the incoming word into the 47-entry one-hot map.
    always_comb begin
        op  = '0;
        fmt = FmtR;
        case (opcode)
            7'h33: begin
                fmt = FmtR;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'd0: op[0] = 1'b1;
                        3'd1: op[2] = 1'b1;
                        3'd2: op[3] = 1'b1;
                        3'd3: op[4] = 1'b1;
                        3'd4: op[5] = 1'b1;
                        3'd5: op[6] = 1'b1;
                        3'd6: op[8] = 1'b1;
                        default: op[9] = 1'b1;
                    endcase
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'd0) op[1] = 1'b1;
                    if (funct3 == 3'd5) op[7] = 1'b1;
                end
`ifdef DECODE_RV32M_EN
                else if (funct7 == 7'h01) begin
                    op[6'd37 + {3'd0, funct3}] = 1'b1;
                end
`endif
            end
            7'h13: begin
                fmt = FmtI;
                case (funct3)
                    3'd0: op[10] = 1'b1;
                    3'd2: op[11] = 1'b1;
                    3'd3: op[12] = 1'b1;
                    3'd4: op[13] = 1'b1;
                    3'd6: op[14] = 1'b1;
                    3'd7: op[15] = 1'b1;
                    // Shift-immediates: funct7 must be exactly 0x00 / 0x20.
                    3'd1: op[16] = (funct7 == 7'h00);
                    default: begin
                        op[17] = (funct7 == 7'h00);
                        op[18] = (funct7 == 7'h20);
                    end
                endcase
            end
            7'h03: begin
                fmt = FmtI;
                case (funct3)
                    3'd0: op[19] = 1'b1;
                    3'd1: op[20] = 1'b1;
                    3'd2: op[21] = 1'b1;
                    3'd4: op[22] = 1'b1;
                    3'd5: op[23] = 1'b1;
                    default: ;
                endcase
            end
            7'h23: begin
                fmt = FmtS;
                case (funct3)
                    3'd0: op[24] = 1'b1;
                    3'd1: op[25] = 1'b1;
                    3'd2: op[26] = 1'b1;
                    default: ;
                endcase
            end
            7'h63: begin
                fmt = FmtB;
                case (funct3)
                    3'd0: op[27] = 1'b1;
                    3'd1: op[28] = 1'b1;
                    3'd4: op[29] = 1'b1;
                    3'd5: op[30] = 1'b1;
                    3'd6: op[31] = 1'b1;
                    3'd7: op[32] = 1'b1;
                    default: ;
                endcase
            end
            7'h6f: begin
                fmt    = FmtJ;
                op[33] = 1'b1;
            end
            7'h67: begin
                fmt    = FmtI;
                op[34] = (funct3 == 3'd0);
            end
            7'h37: begin
                fmt    = FmtU;
                op[35] = 1'b1;
            end
            7'h17: begin
                fmt    = FmtU;
                op[36] = 1'b1;
            end
            7'h0f: begin
                fmt    = FmtI;
                op[45] = (funct3 == 3'd0);
            end
            7'h73: begin
                fmt    = FmtI;
                op[46] = (bus.instr[31:7] == 25'd0) || (bus.instr[31:7] == 25'h2000);
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_dec = '0;
        if (op != '0) begin
            unique case (fmt)
                FmtI: imm_dec = {{20{bus.instr[31]}}, bus.instr[31:20]};
                FmtS: imm_dec = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
                FmtB: imm_dec = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                                 bus.instr[30:25], bus.instr[11:8], 1'b0};
                FmtU: imm_dec = {bus.instr[31:12], 12'd0};
                FmtJ: imm_dec = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                                 bus.instr[20], bus.instr[30:21], 1'b0};
                default: imm_dec = '0;
            endcase
        end
    end

    // Output register stage and handshake.
    logic           out_valid_q, out_valid_d;
    logic [OPW-1:0] instructions_q, instructions_d;
    logic [4:0]     rs1_q, rs2_q, rd_q;
    logic [31:0]    imm_q, pc_q;
    logic           illegal_q, illegal_d;
    logic [31:0]    dec_count_q, dec_count_d;
    logic           in_ready;
    logic           load;

    assign in_ready = !out_valid_q || bus.out_ready;
    // A word presented during flush is dropped.
    assign load     = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        instructions_d = OPW'(op);
        illegal_d      = (op == '0);
        out_valid_d    = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        dec_count_d = dec_count_q;
        if (out_valid_q && bus.out_ready && !bus.flush) begin
            dec_count_d = dec_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            instructions_q <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            illegal_q      <= 1'b0;
            dec_count_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dec_count_q <= dec_count_d;
            if (load) begin
                instructions_q <= instructions_d;
                rs1_q          <= bus.instr[19:15];
                rs2_q          <= bus.instr[24:20];
                rd_q           <= bus.instr[11:7];
                imm_q          <= imm_dec;
                pc_q           <= bus.pc_in;
                illegal_q      <= illegal_d;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.instructions = instructions_q;
    assign bus.rs1_addr     = rs1_q;
    assign bus.rs2_addr     = rs2_q;
    assign bus.rd_addr      = rd_q;
    assign bus.imm          = imm_q;
    assign bus.PC           = pc_q;
    assign bus.illegal      = illegal_q;
    assign bus.dec_count    = dec_count_q;
endmodule
